// File: rtl/mac_pkg.sv
// mac_pkg: shared constants, the CRC-32 byte step and the frame descriptor
// type used by the MAC receive frame filter and its frame buffer.
package mac_pkg;

  localparam logic [7:0]  MAC_PRE_BYTE  = 8'h55;
  localparam logic [7:0]  MAC_SFD_BYTE  = 8'hD5;
  localparam int          MAC_FCS_LEN   = 4;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  // Width of every frame length / byte count carried around the block.
  localparam int          MAC_LEN_W     = 16;

  // One committed frame: number of bytes to replay (FCS removed) and the
  // bad-frame flag that ends up on the user sideband of the last beat.
  typedef struct packed {
    logic [MAC_LEN_W-1:0] len;
    logic                 bad;
  } mac_desc_t;

  // Reflected CRC-32 advanced by one byte, LSB first, no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/mac_frame_buffer.sv
// mac_frame_buffer: store-and-forward byte RAM with a speculative write
// pointer (advanced while a frame arrives) and a committed write pointer
// (moved only once the frame is accepted), plus the descriptor FIFO that
// tells the read side how many committed bytes each frame owns.
module mac_frame_buffer
  import mac_pkg::*;
#(
  parameter int DATA_DEPTH = 2048,
  parameter int DESC_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       data_full,
  input  logic       commit,
  input  logic       rollback,
  input  mac_desc_t  commit_desc,
  output logic       desc_full,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  input  logic       desc_pop,
  output logic       desc_valid,
  output mac_desc_t  desc_head
);

  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int QAW = $clog2(DESC_DEPTH);

  logic [7:0]  data_mem [DATA_DEPTH];
  logic [DAW:0] wr_spec;
  logic [DAW:0] wr_commit;
  logic [DAW:0] rd_ptr;

  mac_desc_t   desc_mem [DESC_DEPTH];
  logic [QAW:0] desc_wp;
  logic [QAW:0] desc_rp;

  // Full is measured against the read pointer, so unread bytes of any
  // committed frame can never be overwritten by a newer frame.
  assign data_full  = (wr_spec[DAW] != rd_ptr[DAW]) &&
                      (wr_spec[DAW-1:0] == rd_ptr[DAW-1:0]);
  assign rd_data    = data_mem[rd_ptr[DAW-1:0]];

  assign desc_full  = (desc_wp[QAW] != desc_rp[QAW]) &&
                      (desc_wp[QAW-1:0] == desc_rp[QAW-1:0]);
  assign desc_valid = (desc_wp != desc_rp);
  assign desc_head  = desc_mem[desc_rp[QAW-1:0]];

  // Byte RAM write port; no reset so it maps onto RAM resources.
  always_ff @(posedge clk) begin
    if (wr_en && !data_full) data_mem[wr_spec[DAW-1:0]] <= wr_data;
  end

  // Data pointers: rollback rewinds the speculative pointer, commit publishes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_spec   <= '0;
      wr_commit <= '0;
      rd_ptr    <= '0;
    end else begin
      if (rollback)                wr_spec <= wr_commit;
      else if (wr_en && !data_full) wr_spec <= wr_spec + 1'b1;
      if (commit)                  wr_commit <= wr_spec;
      if (rd_en)                   rd_ptr    <= rd_ptr + 1'b1;
    end
  end

  // Descriptor storage, written only on a commit that found room.
  always_ff @(posedge clk) begin
    if (commit && !desc_full) desc_mem[desc_wp[QAW-1:0]] <= commit_desc;
  end

  // Descriptor FIFO pointers; push and pop are independent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      desc_wp <= '0;
      desc_rp <= '0;
    end else begin
      if (commit && !desc_full)  desc_wp <= desc_wp + 1'b1;
      if (desc_pop && desc_valid) desc_rp <= desc_rp + 1'b1;
    end
  end

endmodule

// File: rtl/mac_rx_frame_filter.sv
// mac_rx_frame_filter: strips preamble/SFD, checks CRC-32, length and PHY
// error, buffers each frame and replays it (FCS removed) as a ready/valid
// byte stream with last/user framing.
// Optional build macro MAC_DROP_BAD_FRAME_EN: when defined, bad frames are
// rolled back instead of being forwarded with user=1.
module mac_rx_frame_filter
  import mac_pkg::*;
#(
  parameter int DATA_DEPTH    = 2048,
  parameter int DESC_DEPTH    = 16,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic       logic_clk,
  input  logic       logic_rst,
  input  logic [7:0] phy_rxd_in,
  input  logic       phy_rvalid_in,
  input  logic       phy_rerr_in,
  output logic [7:0] mac_data_out,
  output logic       mac_valid_out,
  input  logic       mac_ready_in,
  output logic       mac_last_out,
  output logic       mac_user_out,
  output logic       stat_good_pulse,
  output logic       stat_bad_pulse,
  output logic       stat_drop_pulse
);

`ifdef MAC_DROP_BAD_FRAME_EN
  localparam bit DROP_BAD = 1'b1;
`else
  localparam bit DROP_BAD = 1'b0;
`endif

  localparam logic [1:0] RX_IDLE    = 2'd0;
  localparam logic [1:0] RX_PRE     = 2'd1;
  localparam logic [1:0] RX_DATA    = 2'd2;
  localparam logic [1:0] RX_DISCARD = 2'd3;

  localparam logic       TX_IDLE    = 1'b0;
  localparam logic       TX_SEND    = 1'b1;

  localparam logic [MAC_LEN_W-1:0] LEN_MIN = MAC_LEN_W'(MIN_FRAME_LEN);
  localparam logic [MAC_LEN_W-1:0] LEN_MAX = MAC_LEN_W'(MAX_FRAME_LEN);
  localparam logic [MAC_LEN_W-1:0] LEN_SAT = MAC_LEN_W'(MAX_FRAME_LEN + 1);
  localparam logic [MAC_LEN_W-1:0] LEN_FCS = MAC_LEN_W'(MAC_FCS_LEN);
  localparam logic [MAC_LEN_W-1:0] LEN_ONE = MAC_LEN_W'(1);

  logic [1:0]           rx_state;
  logic [2:0]           pre_cnt;
  logic [31:0]          crc_reg;
  logic [MAC_LEN_W-1:0] len_reg;
  logic [31:0]          dly;
  logic                 err_seen;
  logic                 ovf;

  logic                 tx_state;
  logic [MAC_LEN_W-1:0] tx_cnt;
  logic                 tx_bad;

  logic       pre_stay, pre_sfd, pre_drop;
  logic       store_byte, wr_en, data_full, desc_full;
  logic       frame_end, frame_bad, do_commit, do_rollback;
  logic       tx_load, rd_en, desc_pop, desc_valid;
  logic [7:0] rd_data;
  mac_desc_t  commit_desc, desc_head;

  assign pre_stay = phy_rvalid_in && (phy_rxd_in == MAC_PRE_BYTE) && (pre_cnt < 3'd7);
  assign pre_sfd  = phy_rvalid_in && (phy_rxd_in == MAC_SFD_BYTE);
  assign pre_drop = (rx_state == RX_PRE) && !pre_stay && !pre_sfd;

  // Bytes beyond MAX_FRAME_LEN are not stored, which keeps the stored byte
  // count equal to the saturated length minus the FCS for oversize frames.
  assign store_byte = (rx_state == RX_DATA) && phy_rvalid_in && !ovf &&
                      (len_reg >= LEN_FCS) && (len_reg <= LEN_MAX);
  assign wr_en      = store_byte && !data_full;

  assign frame_end = (rx_state == RX_DATA) && !phy_rvalid_in;
  assign frame_bad = (crc_reg != CRC32_RESIDUE) || (len_reg < LEN_MIN) ||
                     (len_reg > LEN_MAX) || err_seen;

  // A frame no longer than the FCS leaves no byte to carry last/user, so it
  // is always rolled back even when bad frames are otherwise forwarded.
  assign do_rollback = frame_end && (ovf || desc_full || (len_reg <= LEN_FCS) ||
                                     (DROP_BAD && frame_bad));
  assign do_commit   = frame_end && !do_rollback;

  assign commit_desc.len = len_reg - LEN_FCS;
  assign commit_desc.bad = frame_bad;

  assign tx_load  = !mac_valid_out || mac_ready_in;
  assign rd_en    = (tx_state == TX_SEND) && tx_load && (tx_cnt != '0);
  assign desc_pop = desc_valid && ((tx_state == TX_IDLE) ||
                                   ((tx_state == TX_SEND) && tx_load && (tx_cnt == '0)));

  mac_frame_buffer #(
    .DATA_DEPTH (DATA_DEPTH),
    .DESC_DEPTH (DESC_DEPTH)
  ) u_buffer (
    .clk         (logic_clk),
    .rst         (logic_rst),
    .wr_en       (wr_en),
    .wr_data     (dly[31:24]),
    .data_full   (data_full),
    .commit      (do_commit),
    .rollback    (do_rollback),
    .commit_desc (commit_desc),
    .desc_full   (desc_full),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .desc_pop    (desc_pop),
    .desc_valid  (desc_valid),
    .desc_head   (desc_head)
  );

  // RX FSM: preamble/SFD hunt, then CRC, length and FCS delay line per byte.
  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      rx_state <= RX_IDLE;
      pre_cnt  <= '0;
      crc_reg  <= CRC32_INIT;
      len_reg  <= '0;
      dly      <= '0;
      err_seen <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (phy_rvalid_in) begin
            if (phy_rxd_in == MAC_PRE_BYTE) begin
              rx_state <= RX_PRE;
              pre_cnt  <= 3'd1;
              err_seen <= phy_rerr_in;
            end else begin
              rx_state <= RX_DISCARD;
            end
          end
        end
        RX_PRE: begin
          err_seen <= err_seen | (phy_rvalid_in & phy_rerr_in);
          if (pre_stay) begin
            pre_cnt <= pre_cnt + 3'd1;
          end else if (pre_sfd) begin
            rx_state <= RX_DATA;
            crc_reg  <= CRC32_INIT;
            len_reg  <= '0;
            ovf      <= 1'b0;
          end else begin
            rx_state <= RX_DISCARD;
          end
        end
        RX_DATA: begin
          if (phy_rvalid_in) begin
            crc_reg  <= crc32_byte(crc_reg, phy_rxd_in);
            if (len_reg != LEN_SAT) len_reg <= len_reg + 1'b1;
            dly      <= {dly[23:0], phy_rxd_in};
            err_seen <= err_seen | phy_rerr_in;
            if (store_byte && data_full) ovf <= 1'b1;
          end else begin
            rx_state <= RX_IDLE;
          end
        end
        default: begin
          if (!phy_rvalid_in) rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  // Statistics pulses, registered one cycle after the frame decision.
  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      stat_good_pulse <= 1'b0;
      stat_bad_pulse  <= 1'b0;
      stat_drop_pulse <= 1'b0;
    end else begin
      stat_good_pulse <= do_commit && !frame_bad;
      stat_bad_pulse  <= frame_end && frame_bad;
      stat_drop_pulse <= do_rollback || pre_drop;
    end
  end

  // TX FSM: pop a descriptor and replay its bytes through the output register.
  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      tx_state      <= TX_IDLE;
      tx_cnt        <= '0;
      tx_bad        <= 1'b0;
      mac_valid_out <= 1'b0;
      mac_data_out  <= '0;
      mac_last_out  <= 1'b0;
      mac_user_out  <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (desc_valid) begin
            tx_state <= TX_SEND;
            tx_cnt   <= desc_head.len;
            tx_bad   <= desc_head.bad;
          end
        end
        default: begin
          if (tx_load) begin
            if (tx_cnt != '0) begin
              mac_valid_out <= 1'b1;
              mac_data_out  <= rd_data;
              mac_last_out  <= (tx_cnt == LEN_ONE);
              mac_user_out  <= !DROP_BAD && (tx_cnt == LEN_ONE) && tx_bad;
              tx_cnt        <= tx_cnt - 1'b1;
            end else begin
              mac_valid_out <= 1'b0;
              mac_last_out  <= 1'b0;
              mac_user_out  <= 1'b0;
              if (desc_valid) begin
                tx_cnt <= desc_head.len;
                tx_bad <= desc_head.bad;
              end else begin
                tx_state <= TX_IDLE;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rx_frame_filter.sv
// tb_mac_rx_frame_filter: directed frames with a scoreboard queue of expected
// output beats, a decoupled monitor, and stat pulse counters.
`timescale 1ns/1ps
module tb_mac_rx_frame_filter;

  localparam int DATA_DEPTH = 256;
  localparam int DESC_DEPTH = 16;
  localparam int MIN_LEN    = 64;
  localparam int MAX_LEN    = 200;

`ifdef MAC_DROP_BAD_FRAME_EN
  localparam bit DROP_BAD = 1'b1;
`else
  localparam bit DROP_BAD = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  logic       logic_clk = 1'b0;
  logic       logic_rst = 1'b1;
  logic [7:0] phy_rxd_in = 8'h00;
  logic       phy_rvalid_in = 1'b0;
  logic       phy_rerr_in = 1'b0;
  logic [7:0] mac_data_out;
  logic       mac_valid_out;
  logic       mac_ready_in;
  logic       mac_last_out;
  logic       mac_user_out;
  logic       stat_good_pulse;
  logic       stat_bad_pulse;
  logic       stat_drop_pulse;

  int n_compared = 0;
  int n_mismatched = 0;
  int got_good = 0, got_bad = 0, got_drop = 0;
  int exp_good = 0, exp_bad = 0, exp_drop = 0;
  int ready_mode = 0;

  beat_t      exp_q[$];
  beat_t      mon_exp;
  logic [7:0] frm[$];

  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0, prev_user = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 logic_clk = ~logic_clk;

  mac_rx_frame_filter #(
    .DATA_DEPTH    (DATA_DEPTH),
    .DESC_DEPTH    (DESC_DEPTH),
    .MIN_FRAME_LEN (MIN_LEN),
    .MAX_FRAME_LEN (MAX_LEN)
  ) dut (
    .logic_clk       (logic_clk),
    .logic_rst       (logic_rst),
    .phy_rxd_in      (phy_rxd_in),
    .phy_rvalid_in   (phy_rvalid_in),
    .phy_rerr_in     (phy_rerr_in),
    .mac_data_out    (mac_data_out),
    .mac_valid_out   (mac_valid_out),
    .mac_ready_in    (mac_ready_in),
    .mac_last_out    (mac_last_out),
    .mac_user_out    (mac_user_out),
    .stat_good_pulse (stat_good_pulse),
    .stat_bad_pulse  (stat_bad_pulse),
    .stat_drop_pulse (stat_drop_pulse)
  );

  // Downstream ready: held high, held low, or randomly toggled.
  initial begin
    mac_ready_in = 1'b0;
    forever begin
      @(posedge logic_clk);
      #1;
      case (ready_mode)
        0:       mac_ready_in = 1'b1;
        1:       mac_ready_in = 1'b0;
        default: mac_ready_in = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Monitor: count pulses, check stall hold, pop and compare accepted beats.
  always @(negedge logic_clk) begin
    if (stat_good_pulse) got_good++;
    if (stat_bad_pulse)  got_bad++;
    if (stat_drop_pulse) got_drop++;
    if (logic_rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        n_compared++;
        if (!mac_valid_out || mac_data_out !== prev_data ||
            mac_last_out !== prev_last || mac_user_out !== prev_user) begin
          n_mismatched++;
          $display("[TB] FAIL stall_hold: got v=%0b d=%02h l=%0b u=%0b, want v=1 d=%02h l=%0b u=%0b",
                   mac_valid_out, mac_data_out, mac_last_out, mac_user_out,
                   prev_data, prev_last, prev_user);
        end
      end
      if (mac_valid_out && mac_ready_in) begin
        n_compared++;
        if (exp_q.size() == 0) begin
          n_mismatched++;
          $display("[TB] FAIL unexpected_beat: got d=%02h l=%0b u=%0b, want no beat",
                   mac_data_out, mac_last_out, mac_user_out);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mac_data_out !== mon_exp.data || mac_last_out !== mon_exp.last ||
              mac_user_out !== mon_exp.user) begin
            n_mismatched++;
            $display("[TB] FAIL beat: got d=%02h l=%0b u=%0b, want d=%02h l=%0b u=%0b",
                     mac_data_out, mac_last_out, mac_user_out,
                     mon_exp.data, mon_exp.last, mon_exp.user);
          end
        end
      end
      prev_valid = mac_valid_out;
      prev_ready = mac_ready_in;
      prev_data  = mac_data_out;
      prev_last  = mac_last_out;
      prev_user  = mac_user_out;
    end
  end

  function automatic logic [31:0] ref_crc_step(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Frame of total_len bytes (DA..FCS) with a correct FCS appended LSB first.
  task automatic build_frame(input int total_len, input int seed);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    c = 32'hFFFFFFFF;
    for (int k = 0; k < total_len - 4; k++) begin
      b = 8'(seed + 29 * k + (k >> 2));
      frm.push_back(b);
      c = ref_crc_step(c, b);
    end
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic e);
    @(posedge logic_clk);
    #1;
    phy_rxd_in    = b;
    phy_rvalid_in = 1'b1;
    phy_rerr_in   = e;
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(posedge logic_clk);
      #1;
      phy_rxd_in    = 8'h00;
      phy_rvalid_in = 1'b0;
      phy_rerr_in   = 1'b0;
    end
  endtask

  // Push the expected beats for frm, then send it behind n_pre preamble bytes.
  task automatic applyStimulus(input int n_pre, input bit bad_pre, input int err_idx,
                               input bit exp_emit, input bit exp_user);
    beat_t e;
    if (exp_emit) begin
      for (int k = 0; k < frm.size() - 4; k++) begin
        e.data = frm[k];
        e.last = (k == frm.size() - 5);
        e.user = exp_user && e.last;
        exp_q.push_back(e);
      end
    end
    if (bad_pre) begin
      repeat (3) drive_byte(8'h55, 1'b0);
      drive_byte(8'hAA, 1'b0);
      for (int k = 0; k < 10; k++) drive_byte(frm[k], 1'b0);
    end else begin
      repeat (n_pre) drive_byte(8'h55, 1'b0);
      drive_byte(8'hD5, 1'b0);
      for (int k = 0; k < frm.size(); k++) drive_byte(frm[k], k == err_idx);
    end
    drive_idle(3);
  endtask

  task automatic checkIdleOutputs(input string name);
    n_compared++;
    if ({mac_valid_out, mac_last_out, mac_user_out, mac_data_out,
         stat_good_pulse, stat_bad_pulse, stat_drop_pulse} !== 14'h0) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got v=%0b l=%0b u=%0b d=%02h g=%0b b=%0b dr=%0b, want all 0", name,
               mac_valid_out, mac_last_out, mac_user_out, mac_data_out,
               stat_good_pulse, stat_bad_pulse, stat_drop_pulse);
    end
  endtask

  // Drain owed beats (bounded), then compare the stat pulse totals.
  task automatic checkOutput(input string name);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 5000) begin
      @(negedge logic_clk);
      waited++;
    end
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL %s_drain: %0d beats still owed after %0d cycles, want 0",
               name, exp_q.size(), waited);
      exp_q.delete();
    end
    repeat (20) @(negedge logic_clk);
    n_compared++;
    if (got_good != exp_good) begin
      n_mismatched++;
      $display("[TB] FAIL %s_good: got %0d pulses, want %0d", name, got_good, exp_good);
    end
    n_compared++;
    if (got_bad != exp_bad) begin
      n_mismatched++;
      $display("[TB] FAIL %s_bad: got %0d pulses, want %0d", name, got_bad, exp_bad);
    end
    n_compared++;
    if (got_drop != exp_drop) begin
      n_mismatched++;
      $display("[TB] FAIL %s_drop: got %0d pulses, want %0d", name, got_drop, exp_drop);
    end
  endtask

  initial begin
    logic [31:0] c;
    logic [7:0]  chk [9];
    int          len, waited;
    bit          corrupt;

    chk = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    c = 32'hFFFFFFFF;
    for (int k = 0; k < 9; k++) c = ref_crc_step(c, chk[k]);
    if (~c != 32'hCBF43926) begin
      $display("[TB] FAIL bench_crc: got %08h, want cbf43926", ~c);
      $fatal(1, "[TB] reference CRC broken");
    end

    repeat (3) @(negedge logic_clk);
    checkIdleOutputs("reset_outputs");
    @(posedge logic_clk);
    #1 logic_rst = 1'b0;
    repeat (3) @(posedge logic_clk);

    $display("[TB] test 1: good 64-byte frame");
    build_frame(64, 16);
    applyStimulus(7, 1'b0, -1, 1'b1, 1'b0);
    exp_good++;
    checkOutput("t1");

    $display("[TB] test 2: PHY error on byte 40");
    build_frame(64, 32);
    applyStimulus(7, 1'b0, 40, !DROP_BAD, 1'b1);
    exp_bad++;
    if (DROP_BAD) exp_drop++;
    checkOutput("t2");

    $display("[TB] test 3: corrupted FCS, then short frame");
    build_frame(64, 48);
    frm[frm.size() - 2] = frm[frm.size() - 2] ^ 8'h5A;
    applyStimulus(7, 1'b0, -1, !DROP_BAD, 1'b1);
    exp_bad++;
    if (DROP_BAD) exp_drop++;
    build_frame(40, 64);
    applyStimulus(2, 1'b0, -1, !DROP_BAD, 1'b1);
    exp_bad++;
    if (DROP_BAD) exp_drop++;
    checkOutput("t3");

    $display("[TB] test 4: bad preamble, eighth preamble byte, then good frame");
    build_frame(64, 80);
    applyStimulus(7, 1'b1, -1, 1'b0, 1'b0);
    exp_drop++;
    build_frame(64, 88);
    applyStimulus(8, 1'b0, -1, 1'b0, 1'b0);
    exp_drop++;
    build_frame(64, 96);
    applyStimulus(1, 1'b0, -1, 1'b1, 1'b0);
    exp_good++;
    checkOutput("t4");

    $display("[TB] test 5: overflow with ready held low");
    ready_mode = 1;
    build_frame(100, 112);
    applyStimulus(7, 1'b0, -1, 1'b1, 1'b0);
    build_frame(100, 128);
    applyStimulus(7, 1'b0, -1, 1'b1, 1'b0);
    build_frame(100, 144);
    applyStimulus(7, 1'b0, -1, 1'b0, 1'b0);
    exp_good += 2;
    exp_drop++;
    repeat (20) @(posedge logic_clk);
    ready_mode = 0;
    checkOutput("t5");

    $display("[TB] test 6: random ready over 20 frames");
    ready_mode = 2;
    for (int i = 0; i < 20; i++) begin
      waited = 0;
      while (exp_q.size() >= 100 && waited < 5000) begin
        @(negedge logic_clk);
        waited++;
      end
      if (waited >= 5000) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL t6_backlog: got %0d beats owed, want below 100", exp_q.size());
      end
      len     = 64 + (i * 23) % 57;
      corrupt = (i % 5 == 3);
      build_frame(len, i * 37 + 5);
      if (corrupt) frm[frm.size() - 1] = frm[frm.size() - 1] ^ 8'h01;
      applyStimulus(1 + i % 7, 1'b0, -1, !(corrupt && DROP_BAD), corrupt);
      if (corrupt) begin
        exp_bad++;
        if (DROP_BAD) exp_drop++;
      end else begin
        exp_good++;
      end
    end
    checkOutput("t6");

    $display("[TB] test 6b: reset mid-frame with a buffered frame");
    ready_mode = 1;
    build_frame(80, 119);
    applyStimulus(7, 1'b0, -1, 1'b0, 1'b0);
    exp_good++;
    build_frame(80, 120);
    repeat (7) drive_byte(8'h55, 1'b0);
    drive_byte(8'hD5, 1'b0);
    for (int k = 0; k < 30; k++) drive_byte(frm[k], 1'b0);
    @(posedge logic_clk);
    #1 logic_rst = 1'b1;
    drive_idle(1);
    repeat (2) @(negedge logic_clk);
    checkIdleOutputs("mid_reset_outputs");
    @(posedge logic_clk);
    #1 logic_rst = 1'b0;
    ready_mode = 0;
    repeat (3) @(negedge logic_clk);
    checkIdleOutputs("post_reset_outputs");
    repeat (200) @(posedge logic_clk);
    build_frame(64, 200);
    applyStimulus(7, 1'b0, -1, 1'b1, 1'b0);
    exp_good++;
    checkOutput("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Watchdog so a stuck design still produces a verdict.
  initial begin
    #600000;
    n_mismatched++;
    $display("[TB] FAIL watchdog: got no completion after 60000 cycles, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/mac_rx_frame_filter.md
Name: mac_rx_frame_filter

Overview:
- Single-clock successor to the MAC receive CRC verifier.
- Accepts a byte stream already synchronised into logic_clk (valid, err).
- Strips preamble/SFD, removes the 4-byte FCS and checks CRC-32, length and PHY error.
- Stores each frame in a parametrised store-and-forward buffer and replays it on a ready/valid byte stream with last/user framing.
- Sits between the PHY receive synchroniser and the MAC receive parser.

Parameters:
- DATA_DEPTH, 2048: payload buffer depth in bytes; power of two, 64 minimum.
- DESC_DEPTH, 16: frame-descriptor FIFO depth; power of two, 2 minimum.
- MIN_FRAME_LEN, 64: minimum frame length in bytes, DA through FCS inclusive.
- MAX_FRAME_LEN, 1518: maximum frame length in bytes, DA through FCS inclusive; must be less than DATA_DEPTH.

Ports:
- logic_clk  in  1  block clock; every port is synchronous to it.
- logic_rst  in  1  asynchronous, active-high reset.
- phy_rxd_in  in  8  received byte.
- phy_rvalid_in  in  1  byte valid; high continuously for one frame, low for at least 1 cycle between frames.
- phy_rerr_in  in  1  PHY error; sampled only while phy_rvalid_in=1.
- mac_data_out  out  8  frame byte, FCS excluded.
- mac_valid_out  out  1  output beat valid.
- mac_ready_in  in  1  downstream ready.
- mac_last_out  out  1  final byte of frame.
- mac_user_out  out  1  qualified by last; 1 = bad frame.
- stat_good_pulse  out  1  1-cycle pulse when a good frame is committed.
- stat_bad_pulse  out  1  1-cycle pulse when a frame is classed bad (CRC, length, err).
- stat_drop_pulse  out  1  1-cycle pulse when a frame is discarded (preamble error, overflow, or bad with drop enabled).

Behaviour:
Reset:
- All outputs are 0.
- Both FIFOs are empty.
- RX FSM is IDLE; TX FSM is IDLE.
- Reset mid-frame discards all buffered and partial frames.

RX FSM: IDLE -> PRE -> DATA -> IDLE, plus DISCARD.
- IDLE:
  - phy_rvalid_in=1 with byte 0x55 -> PRE, preamble count = 1.
  - Any other byte -> DISCARD.
- PRE:
  - 0x55 with count < 7 -> stay in PRE, count+1.
  - 0xD5 with count >= 1 -> DATA, CRC register = 0xFFFFFFFF, length = 0.
  - Anything else, or an 8th 0x55 -> DISCARD plus stat_drop_pulse.
- DATA, per valid byte:
  - Update the CRC (reflected polynomial 0xEDB88320, LSB first).
  - Length +1, saturating at MAX_FRAME_LEN+1.
  - Shift the byte into a 4-deep delay line; the byte leaving the delay line is written to the data FIFO at the speculative write pointer.
  - The final 4 bytes are therefore never written.
- DATA end (phy_rvalid_in falls) -> IDLE. The frame is bad if any of:
  - CRC register != 0xDEBB20E3;
  - length < MIN_FRAME_LEN or length > MAX_FRAME_LEN;
  - phy_rerr_in was seen during PRE or DATA.
- DISCARD: wait for phy_rvalid_in=0, then IDLE. Nothing is written.
- Commit (cycle after rvalid falls):
  - Committed write pointer = speculative pointer.
  - Descriptor {length-4, bad} is pushed.
  - Good/bad pulse is asserted.
- Rollback:
  - Speculative pointer = committed pointer.
  - No descriptor is pushed.
  - stat_drop_pulse is asserted.
- Overflow: if the data FIFO fills or the descriptor FIFO is full at commit, the frame rolls back. Remaining bytes of the frame are ignored until rvalid falls.
- Read side never sees uncommitted bytes.

TX FSM: IDLE -> SEND.
- IDLE: when the descriptor FIFO is non-empty, pop it, load the byte counter, go to SEND.
- SEND output beats:
  - Registered outputs.
  - A beat holds stable while valid=1 and ready=0.
  - mac_last_out=1 on counter = 1, with mac_user_out = descriptor bad bit.
  - After the last beat is accepted -> IDLE.
- Latency: first output byte appears no earlier than 3 cycles after commit.
- Back-to-back frames may have 1 idle cycle between them.
- Read and write in the same cycle are independent; full and empty use a pointer extra MSB.

Optional Feature:
- Macro: MAC_DROP_BAD_FRAME_EN.
- Defined:
  - Bad frames roll back and are never emitted.
  - mac_user_out is tied to 0.
  - stat_bad_pulse and stat_drop_pulse both fire.
- Undefined:
  - Bad frames are committed and emitted with mac_user_out=1 on last.
  - Only stat_bad_pulse fires.

Decomposition:
- Package mac_pkg holds:
  - MAC_PRE_BYTE=8'h55, MAC_SFD_BYTE=8'hD5, MAC_FCS_LEN=4;
  - CRC32_POLY=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF, CRC32_RESIDUE=32'hDEBB20E3;
  - function crc32_byte(crc, byte);
  - typedef mac_desc_t {len, bad}.
- Sub-module mac_frame_buffer: data RAM with speculative/committed write pointers, commit/rollback inputs, descriptor FIFO.
- The top level keeps both FSMs and the CRC logic.

Test Plan:
1. Good 72-byte frame: 7×0x55, 0xD5, 64 bytes, valid FCS -> 60 bytes out, last on byte 60, user=0, one stat_good_pulse.
2. Same frame with phy_rerr_in pulsed on byte 40:
   - Drop undefined: 60 bytes out, user=1.
   - Drop defined: no output, stat_drop_pulse.
3. Corrupted FCS byte, and separately a 40-byte frame -> stat_bad_pulse; user=1 (drop undefined).
4. Bad preamble (0x55×3, 0xAA) -> DISCARD, stat_drop_pulse, no output; the next good frame passes intact.
5. mac_ready_in=0 while 3 good 100-byte frames arrive with DATA_DEPTH=256:
   - Third frame overflows -> rolled back, stat_drop_pulse.
   - After ready=1: exactly 2 frames of 96 bytes each, data matching.
6. Random ready toggling over 20 frames, plus logic_rst asserted mid-frame:
   - Output equals the scoreboard and outputs hold under stall.
   - After reset: all outputs 0 and no stale frame emitted.
